// File: rtl/lane_assist_actuator.sv
// Lane-assist actuator: debounces the 3-bit command code and drives a ramped steering torque.
// Optional build macro LA_DRIVER_OVERRIDE_EN adds a driver_override input that aborts corrections.
module lane_assist_actuator #(
    parameter int DEBOUNCE = 4,
    parameter int TORQ_W   = 4,
    parameter int TORQ_MAX = 12,
    parameter int RAMP_DIV = 2,
    parameter int HOLD_MAX = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        lane,
`ifdef LA_DRIVER_OVERRIDE_EN
    input  logic              driver_override,
`endif
    output logic [TORQ_W-1:0] torque,
    output logic              steer_right,
    output logic              steer_left,
    output logic              warn_chime,
    output logic              takeover_req,
    output logic              fault
);

    localparam int STAB_W = 4;
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    localparam logic [2:0] CODE_DISABLE = 3'b000;
    localparam logic [2:0] CODE_RIGHT   = 3'b001;
    localparam logic [2:0] CODE_ENABLE  = 3'b010;
    localparam logic [2:0] CODE_LEFT    = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        OFF,
        CORR_R,
        CORR_L,
        RELEASE,
        TAKEOVER,
        FAULT
    } state_t;

    state_t state, state_n;

    logic [2:0]        lane_q;
    logic [2:0]        cmd;
    logic [STAB_W-1:0] stable_cnt;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n, hold_inc;
    logic [TORQ_W-1:0] torque_n, torque_inc;
    logic              dir_right, dir_left, dir_right_n, dir_left_n;
    logic              ramp_tick;
    logic              cmd_illegal;
    logic              override_act;

`ifdef LA_DRIVER_OVERRIDE_EN
    assign override_act = driver_override;
`else
    assign override_act = 1'b0;
`endif

    // A code is only accepted once the sampled value has been stable for DEBOUNCE edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_q     <= CODE_ENABLE;
            cmd        <= CODE_ENABLE;
            stable_cnt <= '0;
        end else begin
            lane_q <= lane;
            if (lane != lane_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt == STAB_W'(DEBOUNCE - 1)) begin
                cmd <= lane_q;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign cmd_illegal = (cmd != CODE_DISABLE) && (cmd != CODE_RIGHT) &&
                         (cmd != CODE_ENABLE)  && (cmd != CODE_LEFT);
    assign hold_inc    = hold_cnt + 1'b1;
    assign ramp_tick   = (div_cnt == DIV_W'(RAMP_DIV - 1));
    assign torque_inc  = (torque == TORQ_W'(TORQ_MAX)) ? torque : torque + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Takeover is checked before release so a timed-out correction never just fades away
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (cmd == CODE_RIGHT && !override_act) begin
                    state_n = CORR_R;
                end else if (cmd == CODE_LEFT && !override_act) begin
                    state_n = CORR_L;
                end else if (cmd == CODE_DISABLE) begin
                    state_n = OFF;
                end
            end
            OFF: begin
                if (cmd == CODE_ENABLE) begin
                    state_n = IDLE;
                end
            end
            CORR_R: begin
                if (hold_inc == HOLD_W'(HOLD_MAX)) begin
                    state_n = TAKEOVER;
                end else if (cmd != CODE_RIGHT || override_act) begin
                    state_n = RELEASE;
                end
            end
            CORR_L: begin
                if (hold_inc == HOLD_W'(HOLD_MAX)) begin
                    state_n = TAKEOVER;
                end else if (cmd != CODE_LEFT || override_act) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (torque == '0) begin
                    case (cmd)
                        CODE_ENABLE:  state_n = IDLE;
                        CODE_DISABLE: state_n = OFF;
                        CODE_RIGHT:   state_n = override_act ? RELEASE : CORR_R;
                        CODE_LEFT:    state_n = override_act ? RELEASE : CORR_L;
                        default:      state_n = RELEASE;
                    endcase
                end
            end
            TAKEOVER: begin
                if (cmd == CODE_ENABLE) begin
                    state_n = IDLE;
                end else if (cmd == CODE_DISABLE) begin
                    state_n = OFF;
                end
            end
            default: state_n = FAULT;
        endcase
        if (cmd_illegal) begin
            state_n = FAULT;
        end
    end

    // Entering a correction applies the first torque step at once; leaving one holds torque for the ramp-down
    always_comb begin
        torque_n    = torque;
        div_n       = div_cnt;
        hold_n      = '0;
        dir_right_n = dir_right;
        dir_left_n  = dir_left;
        if (state_n != state) begin
            div_n = '0;
            case (state_n)
                CORR_R: begin
                    torque_n    = torque_inc;
                    dir_right_n = 1'b1;
                    dir_left_n  = 1'b0;
                end
                CORR_L: begin
                    torque_n    = torque_inc;
                    dir_right_n = 1'b0;
                    dir_left_n  = 1'b1;
                end
                RELEASE, TAKEOVER: begin
                    torque_n = torque;
                end
                default: begin
                    torque_n    = '0;
                    dir_right_n = 1'b0;
                    dir_left_n  = 1'b0;
                end
            endcase
        end else begin
            div_n = ramp_tick ? '0 : div_cnt + 1'b1;
            case (state)
                CORR_R, CORR_L: begin
                    hold_n = hold_inc;
                    if (ramp_tick) begin
                        torque_n = torque_inc;
                    end
                end
                RELEASE, TAKEOVER: begin
                    if (ramp_tick && torque != '0) begin
                        torque_n = torque - 1'b1;
                    end
                end
                default: begin
                    torque_n = '0;
                    div_n    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            torque       <= '0;
            div_cnt      <= '0;
            hold_cnt     <= '0;
            dir_right    <= 1'b0;
            dir_left     <= 1'b0;
            steer_right  <= 1'b0;
            steer_left   <= 1'b0;
            warn_chime   <= 1'b0;
            takeover_req <= 1'b0;
            fault        <= 1'b0;
        end else begin
            torque       <= torque_n;
            div_cnt      <= div_n;
            hold_cnt     <= hold_n;
            dir_right    <= dir_right_n;
            dir_left     <= dir_left_n;
            steer_right  <= dir_right_n && (torque_n != '0);
            steer_left   <= dir_left_n && (torque_n != '0);
            warn_chime   <= (state_n == CORR_R) || (state_n == CORR_L) || (state_n == TAKEOVER);
            takeover_req <= (state_n == TAKEOVER);
            fault        <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_lane_assist_actuator.sv
// Directed self-checking bench for lane_assist_actuator at default parameters.
// Override steps are compiled in only when LA_DRIVER_OVERRIDE_EN is defined.
module tb_lane_assist_actuator;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] lane = 3'b010;
    logic [3:0] torque;
    logic       steer_right;
    logic       steer_left;
    logic       warn_chime;
    logic       takeover_req;
    logic       fault;
`ifdef LA_DRIVER_OVERRIDE_EN
    logic       driver_override = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    lane_assist_actuator dut (
        .CLK(CLK),
        .RST(RST),
        .lane(lane),
`ifdef LA_DRIVER_OVERRIDE_EN
        .driver_override(driver_override),
`endif
        .torque(torque),
        .steer_right(steer_right),
        .steer_left(steer_left),
        .warn_chime(warn_chime),
        .takeover_req(takeover_req),
        .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hold a code on lane for a number of rising edges, then settle 1 time unit past the last one
    task automatic applyStimulus(input logic [2:0] code, input int edges);
        lane = code;
        repeat (edges) @(posedge CLK);
        #1;
    endtask

    task automatic resetDut();
        RST  = 1'b1;
        lane = 3'b010;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int expTorque;

        #2 RST = 1'b1;
        #1;
        checkOutput("reset_outputs", {torque, steer_right, steer_left, warn_chime, takeover_req, fault}, 32'd0);
        resetDut();

        applyStimulus(3'b001, 5);
        checkOutput("pre_accept_torque", torque, 32'd0);
        applyStimulus(3'b001, 1);
        checkOutput("entry_torque", torque, 32'd1);
        checkOutput("entry_steer_right", steer_right, 32'd1);
        checkOutput("entry_steer_left", steer_left, 32'd0);
        checkOutput("entry_warn", warn_chime, 32'd1);
        applyStimulus(3'b001, 1);
        checkOutput("edge6_torque", torque, 32'd1);
        applyStimulus(3'b001, 20);
        checkOutput("edge26_torque", torque, 32'd11);
        applyStimulus(3'b001, 1);
        checkOutput("edge27_torque", torque, 32'd12);
        applyStimulus(3'b001, 4);
        checkOutput("saturated_torque", torque, 32'd12);

        applyStimulus(3'b100, 5);
        checkOutput("rev_pre_torque", torque, 32'd12);
        checkOutput("rev_pre_right", steer_right, 32'd1);
        for (int e = 37; e <= 61; e++) begin
            applyStimulus(3'b100, 1);
            expTorque = 12 - (e - 37) / 2;
            checkOutput("rev_ramp_torque", torque, expTorque);
            checkOutput("rev_ramp_left", steer_left, 32'd0);
            checkOutput("rev_ramp_right", steer_right, (expTorque != 0) ? 32'd1 : 32'd0);
        end
        checkOutput("rev_release_warn", warn_chime, 32'd0);
        applyStimulus(3'b100, 1);
        checkOutput("rev_left_torque", torque, 32'd1);
        checkOutput("rev_left_steer", {steer_right, steer_left}, 32'd1);
        checkOutput("rev_left_warn", warn_chime, 32'd1);

        resetDut();
        applyStimulus(3'b001, 3);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'b010, 1);
            checkOutput("short_pulse_quiet", {torque, steer_right, steer_left, warn_chime}, 32'd0);
        end

        resetDut();
        applyStimulus(3'b001, 69);
        checkOutput("pre_takeover_req", takeover_req, 32'd0);
        checkOutput("pre_takeover_torque", torque, 32'd12);
        applyStimulus(3'b001, 1);
        checkOutput("takeover_req", takeover_req, 32'd1);
        checkOutput("takeover_warn", warn_chime, 32'd1);
        checkOutput("takeover_torque", torque, 32'd12);
        applyStimulus(3'b001, 22);
        checkOutput("takeover_ramp1", torque, 32'd1);
        checkOutput("takeover_ramp1_right", steer_right, 32'd1);
        applyStimulus(3'b001, 2);
        checkOutput("takeover_ramp0", torque, 32'd0);
        checkOutput("takeover_ramp0_right", steer_right, 32'd0);
        applyStimulus(3'b001, 6);
        checkOutput("takeover_held", {torque, takeover_req}, 32'd1);
        applyStimulus(3'b010, 5);
        checkOutput("takeover_before_exit", takeover_req, 32'd1);
        applyStimulus(3'b010, 1);
        checkOutput("takeover_exit_req", takeover_req, 32'd0);
        checkOutput("takeover_exit_warn", warn_chime, 32'd0);

        applyStimulus(3'b111, 5);
        checkOutput("fault_pre", fault, 32'd0);
        applyStimulus(3'b111, 1);
        checkOutput("fault_set", fault, 32'd1);
        checkOutput("fault_quiet", {torque, steer_right, steer_left, warn_chime, takeover_req}, 32'd0);
        applyStimulus(3'b001, 10);
        checkOutput("fault_sticky", fault, 32'd1);
        checkOutput("fault_no_torque", {torque, steer_right}, 32'd0);
        #2 RST = 1'b1;
        #1;
        checkOutput("fault_cleared_by_reset", fault, 32'd0);
        resetDut();

        applyStimulus(3'b001, 20);
        checkOutput("mid_torque", torque, 32'd8);
        checkOutput("mid_right", steer_right, 32'd1);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_reset_outputs", {torque, steer_right, steer_left, warn_chime, takeover_req, fault}, 32'd0);
        resetDut();

`ifdef LA_DRIVER_OVERRIDE_EN
        driver_override = 1'b0;
        applyStimulus(3'b100, 12);
        checkOutput("ovr_pre_torque", torque, 32'd4);
        checkOutput("ovr_pre_left", steer_left, 32'd1);
        driver_override = 1'b1;
        applyStimulus(3'b100, 1);
        checkOutput("ovr_release_torque", torque, 32'd4);
        checkOutput("ovr_release_warn", warn_chime, 32'd0);
        applyStimulus(3'b100, 8);
        checkOutput("ovr_ramped_torque", torque, 32'd0);
        checkOutput("ovr_ramped_left", steer_left, 32'd0);
        applyStimulus(3'b100, 10);
        checkOutput("ovr_held_zero", torque, 32'd0);
        driver_override = 1'b0;
        applyStimulus(3'b100, 1);
        checkOutput("ovr_resume_torque", torque, 32'd1);
        checkOutput("ovr_resume_left", steer_left, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_assist_actuator.md
Name: lane_assist_actuator

Overview:
- Consumer end of the 3-bit lane-assist command code: debounces and decodes the code, then drives the steering-correction actuator.
- Converts the code into a ramped, direction-qualified corrective torque command plus a warning chime.
- Escalates to a driver-takeover request if a correction persists too long.
- Latches a sticky fault when an illegal code is received.

Parameters:
- DEBOUNCE, 4, consecutive identical samples required before a new code is accepted (1..15)
- TORQ_W, 4, width of the torque command
- TORQ_MAX, 12, torque saturation value (< 2^TORQ_W)
- RAMP_DIV, 2, clock cycles per ±1 torque step (≥1)
- HOLD_MAX, 64, continuous cycles in a correcting state before takeover

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous reset, active-high
- lane  input  3  command code: 010 enable, 000 disable, 001 assist right, 100 assist left
- torque  output  TORQ_W  corrective torque magnitude
- steer_right  output  1  torque applied rightward
- steer_left  output  1  torque applied leftward
- warn_chime  output  1  driver warning
- takeover_req  output  1  driver must take control
- fault  output  1  illegal code latched, sticky

Behaviour:
Reset:
- Async RST forces all outputs to 0 immediately, including mid-correction.
- Internal state after reset: state=IDLE, accepted code cmd=010, sampled code lane_q=010, all counters 0.

Sampling and debounce:
- lane is registered into lane_q every edge.
- A stable counter clears on any lane_q change and counts while lane_q is unchanged.
- If lane holds a new value from edge n, cmd takes that value at edge n+DEBOUNCE.
- The FSM acts on cmd at the following edge.
- Shorter pulses are ignored.

Illegal codes:
- 011, 101, 110 and 111 are illegal.
- An illegal code accepted into cmd moves the FSM to FAULT.

FSM states:
- IDLE:
  - cmd=001 → CORR_R
  - cmd=100 → CORR_L
  - cmd=000 → OFF
- OFF:
  - torque=0
  - cmd=010 → IDLE
  - cmd=001 or 100 is ignored
- CORR_R / CORR_L:
  - Direction latch is set.
  - torque increments by 1 every RAMP_DIV cycles; the first step lands on the entry edge; saturates at TORQ_MAX.
  - warn_chime=1.
  - The hold counter increments every cycle.
  - cmd≠own direction → RELEASE.
  - hold counter reaching HOLD_MAX → TAKEOVER.
- RELEASE:
  - torque decrements by 1 every RAMP_DIV cycles.
  - At torque=0, go to the state selected by the current cmd: IDLE/OFF/CORR_R/CORR_L.
  - Direction reversal therefore always passes through torque=0.
- TAKEOVER:
  - takeover_req=1 and warn_chime=1.
  - torque ramps down as in RELEASE and is held at 0.
  - Exit only when cmd=010 (→ IDLE) or cmd=000 (→ OFF).
  - takeover_req clears on the exit edge.
- FAULT:
  - torque=0 on entry edge, steer_*=0, fault=1.
  - Absorbing until RST.

Outputs:
- steer_right = right latch & (torque≠0).
- steer_left = left latch & (torque≠0).
- steer_right and steer_left are never both 1.
- All outputs are registered.

Counters:
- The hold counter clears on leaving CORR_*.
- The ramp divider clears on every state change.
- The torque counter is saturating with no wrap; underflow below 0 is prevented.

Simultaneous events:
- FAULT has priority over TAKEOVER.
- TAKEOVER has priority over RELEASE.

Optional Feature:
LA_DRIVER_OVERRIDE_EN
- Defined:
  - Adds input driver_override (1 bit).
  - While it is high, CORR_* goes to RELEASE on the same edge and the hold counter clears.
  - IDLE and RELEASE do not enter CORR_*.
  - TAKEOVER and FAULT are unaffected.
- Undefined: port absent; behaviour as above.

Test Plan:
- Default parameters throughout.
- Reset, then lane=001 held from edge 0:
  - cmd accepted at edge 4.
  - Edge 5: torque=1, steer_right=1, warn_chime=1.
  - torque reaches 12 at edge 27 and stays 12.
- lane=001 for 3 cycles, then 010:
  - torque stays 0 and steer_* stay 0 for 20 cycles.
- Torque at 12 in CORR_R, then lane=100:
  - torque steps 12→0 every 2 cycles.
  - steer_left rises only after torque=0, with torque=1.
  - steer_right and steer_left never both 1.
- lane=001 held 100 cycles:
  - takeover_req=1 on the 64th CORR_R cycle; torque ramps to 0.
  - lane=010 for 4 cycles, then one FSM edge: takeover_req=0, state IDLE.
- lane=111 for 4 cycles:
  - fault=1 and torque=0.
  - lane=001 afterwards: no torque.
  - Only RST clears fault.
- Assert RST during torque=8:
  - All outputs 0 immediately, without waiting for a clock edge.
- With LA_DRIVER_OVERRIDE_EN and driver_override=1 during CORR_L:
  - RELEASE next edge; torque ramps to 0 and stays 0 while asserted.
